// File: rtl/timer_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : timer_display_driver
// Description : Converts timer MSB/LSB binary values to BCD and scans them
//               onto a common-anode 4-digit seven-segment display (MM.SS).
//               Optional macro LEADING_ZERO_BLANK_EN blanks a zero minutes-tens.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  msb_bin,
    input  logic [7:0]  lsb_bin,
    input  logic        blank,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic [15:0] bcd_out,
    output logic        busy,
    output logic        overrange
);

    localparam int                c_cnt_w     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One double-dabble iteration on {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_snap;
    logic               r_snap_valid;
    logic [19:0]        r_dd_msb;
    logic [19:0]        r_dd_lsb;
    logic [2:0]         r_shift_cnt;
    logic [c_cnt_w-1:0] r_scan_cnt;
    logic [1:0]         r_idx;

    logic               w_changed;
    logic               w_capture;
    logic               w_shift;
    logic               w_commit;
    logic               w_msb_over;
    logic               w_lsb_over;
    logic [7:0]         w_msb_digits;
    logic [7:0]         w_lsb_digits;
    logic               w_scan_wrap;
    logic [1:0]         w_idx_next;
    logic [3:0]         w_digit;
    logic               w_lz_blank;
    logic [6:0]         w_seg_n;
    logic [3:0]         w_an_n;
    logic               w_dp_n;

    assign w_changed = !r_snap_valid || ({msb_bin, lsb_bin} != r_snap);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_changed) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_shift_cnt == 3'd7) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A value above 99 leaves a non-zero hundreds nibble; it saturates to 99.
    assign w_msb_over   = (r_dd_msb[19:16] != 4'd0);
    assign w_lsb_over   = (r_dd_lsb[19:16] != 4'd0);
    assign w_msb_digits = w_msb_over ? 8'h99 : r_dd_msb[15:8];
    assign w_lsb_digits = w_lsb_over ? 8'h99 : r_dd_lsb[15:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap       <= 16'h0000;
            r_snap_valid <= 1'b0;
            r_dd_msb     <= 20'h00000;
            r_dd_lsb     <= 20'h00000;
            r_shift_cnt  <= 3'd0;
            bcd_out      <= 16'h0000;
            busy         <= 1'b0;
            overrange    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_snap      <= {msb_bin, lsb_bin};
                r_dd_msb    <= {12'h000, msb_bin};
                r_dd_lsb    <= {12'h000, lsb_bin};
                r_shift_cnt <= 3'd0;
                busy        <= 1'b1;
            end
            if (w_shift) begin
                r_dd_msb    <= dd_step(r_dd_msb);
                r_dd_lsb    <= dd_step(r_dd_lsb);
                r_shift_cnt <= r_shift_cnt + 3'd1;
            end
            if (w_commit) begin
                bcd_out      <= {w_msb_digits, w_lsb_digits};
                overrange    <= w_msb_over | w_lsb_over;
                r_snap_valid <= 1'b1;
                busy         <= 1'b0;
            end
        end
    end

    assign w_scan_wrap = (r_scan_cnt == c_scan_last);
    assign w_idx_next  = w_scan_wrap ? r_idx + 2'd1 : r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + c_cnt_w'(1);
            r_idx      <= w_idx_next;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign w_lz_blank = (w_idx_next == 2'd3) && (bcd_out[15:12] == 4'd0);
`else
    assign w_lz_blank = 1'b0;
`endif

    // Outputs are computed from the upcoming index so the digit changes on the
    // same edge the index advances.
    always_comb begin
        w_digit = 4'd0;
        w_seg_n = 7'h7F;
        w_an_n  = 4'hF;
        w_dp_n  = 1'b1;
        case (w_idx_next)
            2'd0:    w_digit = bcd_out[3:0];
            2'd1:    w_digit = bcd_out[7:4];
            2'd2:    w_digit = bcd_out[11:8];
            default: w_digit = bcd_out[15:12];
        endcase
        if (!blank && !w_lz_blank) begin
            w_seg_n = seg_decode(w_digit);
            w_an_n  = ~(4'b0001 << w_idx_next);
        end
        if (!blank && (w_idx_next == 2'd2)) w_dp_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            an_n  <= 4'hF;
        end else begin
            seg_n <= w_seg_n;
            dp_n  <= w_dp_n;
            an_n  <= w_an_n;
        end
    end

endmodule
`default_nettype wire

// File: doc/timer_display_driver.md
Name: timer_display_driver

Overview:
- Downstream consumer of the timer core's MSB/LSB binary outputs (minutes/seconds, 0–59 nominal).
- Converts both 8-bit values to BCD with an iterative shift-add-3 engine.
- Time-multiplexes the four resulting digits onto a common-anode 4-digit seven-segment display, with the decimal point lit as the MM.SS separator.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is held before the scan advances; legal range ≥ 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- msb_bin  input  8  MSB (minutes) binary value from the timer core
- lsb_bin  input  8  LSB (seconds) binary value from the timer core
- blank  input  1  1 = all anodes off; scan and conversion continue
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  output  1  decimal point, active-low
- an_n  output  4  digit anodes, active-low, one-hot-low
- bcd_out  output  16  committed digits {msb_tens, msb_ones, lsb_tens, lsb_ones}
- busy  output  1  conversion in progress
- overrange  output  1  last committed msb_bin or lsb_bin was > 99

Behaviour:
- Reset (rst_n low at a clock edge) sets:
  - seg_n = 7'h7F, dp_n = 1, an_n = 4'hF
  - bcd_out = 0, busy = 0, overrange = 0
  - scan counter = 0, digit index = 0
  - snapshot-valid flag = 0, FSM in IDLE
- Reset mid-conversion aborts the conversion; no partial commit.
- FSM states and transitions:
  - IDLE: if snapshot-valid = 0, or {msb_bin, lsb_bin} ≠ snapshot, capture both inputs, set busy = 1, go to SHIFT. Inputs are sampled only in IDLE; changes during SHIFT/COMMIT are picked up on the next IDLE cycle.
  - SHIFT: 8 cycles. Two parallel double-dabble engines, 8-bit binary with 12-bit BCD each. Per cycle: add 3 to any BCD nibble ≥ 5, then shift left 1 bit. Go to COMMIT after the 8th shift.
  - COMMIT: one cycle. Load bcd_out, set overrange, set snapshot-valid = 1, busy = 0, go to IDLE.
- Latency: capture at edge N → bcd_out/overrange valid after edge N+9. busy is high for exactly 9 cycles.
- Overrange: a value > 99 commits its two digits as 9,9; the hundreds nibble is discarded and overrange = 1. overrange is cleared by the next commit with both values ≤ 99.
- Scan:
  - Counter runs 0..SCAN_DIV-1. On the edge where the counter is SCAN_DIV-1, it wraps to 0 and the digit index increments 0→1→2→3→0.
  - Digit mapping: idx 0 = lsb_ones (an_n = 1110), 1 = lsb_tens (1101), 2 = msb_ones (1011), 3 = msb_tens (0111).
- Output timing:
  - seg_n, an_n and dp_n are registered and computed from the next-state index and bcd_out.
  - The first edge with rst_n = 1 drives digit 0. Outputs change on the same edge the index advances.
  - A new bcd_out appears on seg_n at the edge after commit.
- dp_n = 0 only when idx = 2 and blank = 0; otherwise 1.
- blank = 1: an_n = 4'hF, seg_n = 7'h7F, dp_n = 1 from the next edge; scan counter and index keep running.
- Segment codes (seg_n):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when idx = 3 and msb_tens = 0, an_n = 4'hF and seg_n = 7'h7F for that slot, so "05.30" displays as " 5.30". Scan timing is unchanged.
- Undefined: the msb tens digit is always driven, including 0.

Test Plan:
- Reset, then msb_bin = 0, lsb_bin = 0 → busy high for 9 cycles starting the edge after reset release; bcd_out = 16'h0000; an_n sequence 1110, 1101, 1011, 0111 with each held SCAN_DIV cycles (bench SCAN_DIV = 4); dp_n = 0 only in the 1011 slot.
- msb_bin = 2, lsb_bin = 59 → 9 cycles later bcd_out = 16'h0259, overrange = 0; idx 0 slot seg_n = 0010000 (9), idx 1 slot seg_n = 0010010 (5).
- lsb_bin sweeps 57, 58, 59, 0 with each value held 20 cycles → bcd_out steps 0257, 0258, 0259, 0200; each busy pulse is exactly 9 cycles.
- msb_bin = 150, lsb_bin = 7 → bcd_out = 16'h9907, overrange = 1; then msb_bin = 1 → overrange = 0, bcd_out = 16'h0107.
- lsb_bin changed at SHIFT cycle 4, then rst_n low for one edge → all outputs at reset values; a fresh conversion of the current inputs starts the edge after release.
- blank = 1 for 10 cycles mid-scan → an_n = 4'hF; after blank = 0, the index matches an unblanked reference count. With LEADING_ZERO_BLANK_EN and msb_bin = 5, the idx 3 slot gives an_n = 4'hF.
